// File: rtl/cpu_irq_arbiter.sv
// cpu_irq_arbiter: picks the highest PIRQ/bus request above PSW priority and handshakes it to the core
module cpu_irq_arbiter #(
  parameter logic [8:0] PIRQ_VEC = 9'o240,
  parameter int HOLDOFF = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [15:0] pir_in,
  input  logic [2:0]  psw_prio,
  input  logic [3:0]  br_req,
  input  logic [35:0] br_vec,
  output logic [3:0]  br_gnt,
  output logic        cpu_irq,
  output logic [2:0]  cpu_irq_lvl,
  output logic [8:0]  cpu_irq_vec,
  input  logic        cpu_iack
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
  state_t state, state_d;
  logic [7:0] cnt;
  logic [2:0] p_lvl, e_lvl, win_lvl;
  logic [1:0] e_k, src_k;
  logic [8:0] win_vec;
  logic ext_win, valid, src_ext, src_live, withdraw, ack, unused_ok;
  assign unused_ok = ^pir_in[8:0];
  always_comb begin
    p_lvl = '0;
    e_lvl = '0;
    e_k = '0;
    for (int i = 1; i < 8; i++) if (pir_in[8+i]) p_lvl = 3'(i);
    for (int k = 0; k < 4; k++) if (br_req[k]) begin
      e_lvl = 3'(4 + k);
      e_k = 2'(k);
    end
  end
  assign ext_win  = e_lvl != 3'd0 && e_lvl >= p_lvl;
  assign win_lvl  = ext_win ? e_lvl : p_lvl;
  assign win_vec  = ext_win ? br_vec[9*e_k +: 9] : PIRQ_VEC;
  assign valid    = win_lvl > psw_prio;
  assign src_live = src_ext ? br_req[src_k] : pir_in[{1'b1, cpu_irq_lvl}];
  assign withdraw = !src_live || psw_prio >= cpu_irq_lvl;
  assign ack      = state == REQ && cpu_iack;
  assign cpu_irq  = state == REQ;
  always_comb begin
    state_d = state;
    state_d = state == IDLE ? (valid ? REQ : IDLE)
            : state == REQ  ? (cpu_iack ? (HOLDOFF == 0 ? IDLE : HOLD) : withdraw ? IDLE : REQ)
            : cnt <= 8'd1   ? IDLE : HOLD;
  end
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state <= IDLE;
      cnt <= '0;
      cpu_irq_lvl <= '0;
      cpu_irq_vec <= '0;
      src_ext <= 1'b0;
      src_k <= '0;
      br_gnt <= '0;
    end else begin
      state <= state_d;
      br_gnt <= ack && src_ext ? 4'd1 << src_k : 4'd0;
      if (state == IDLE && valid) begin
        cpu_irq_lvl <= win_lvl;
        cpu_irq_vec <= win_vec;
        src_ext <= ext_win;
        src_k <= e_k;
      end
      if (ack) cnt <= 8'(HOLDOFF);
      else if (state == HOLD) cnt <= cnt - 8'd1;
    end
  end
endmodule

// File: tb/tb_cpu_irq_arbiter.sv
// tb_cpu_irq_arbiter: directed and random checks of cpu_irq_arbiter against a request-level model
module tb_cpu_irq_arbiter;
  localparam int HOLDOFF = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] pir_in = '0;
  logic [2:0] psw = '0;
  logic [3:0] br_req = '0;
  logic [35:0] br_vec = '0;
  logic iack = 1'b0;
  logic [3:0] br_gnt;
  logic cpu_irq;
  logic [2:0] cpu_irq_lvl;
  logic [8:0] cpu_irq_vec;
  int n_checks = 0;
  int n_pass = 0;
  cpu_irq_arbiter #(.PIRQ_VEC(9'o240), .HOLDOFF(HOLDOFF)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .pir_in(pir_in), .psw_prio(psw),
    .br_req(br_req), .br_vec(br_vec), .br_gnt(br_gnt), .cpu_irq(cpu_irq),
    .cpu_irq_lvl(cpu_irq_lvl), .cpu_irq_vec(cpu_irq_vec), .cpu_iack(iack)
  );
  always #5 clk = ~clk;
  bit m_irq;
  bit [2:0] m_lvl;
  bit [8:0] m_vec;
  bit [3:0] m_gnt;
  int m_src, m_wait, p, e, w;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_irq = 0; m_lvl = 0; m_vec = 0; m_gnt = 0; m_src = 0; m_wait = 0;
    end else begin
      m_gnt = 0;
      if (m_irq) begin
        if (iack) begin
          if (m_src >= 0) m_gnt = 4'(1 << m_src);
          m_irq = 0;
          m_wait = HOLDOFF;
        end else if ((m_src >= 0 ? !br_req[m_src] : !pir_in[8 + int'(m_lvl)]) || psw >= m_lvl)
          m_irq = 0;
      end else if (m_wait > 0) m_wait--;
      else begin
        p = 0;
        e = 0;
        for (int l = 1; l <= 7; l++) if (pir_in[8 + l]) p = l;
        for (int k = 0; k < 4; k++) if (br_req[k]) e = 4 + k;
        w = e >= p ? e : p;
        if (w > 0 && w > int'(psw)) begin
          m_irq = 1;
          m_lvl = 3'(w);
          m_src = e >= p ? e - 4 : -1;
          m_vec = e >= p ? br_vec[9*(e-4) +: 9] : 9'o240;
        end
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic tick();
    @(negedge clk);
    check("irq", 32'(cpu_irq), 32'(m_irq));
    check("lvl", 32'(cpu_irq_lvl), 32'(m_lvl));
    check("vec", 32'(cpu_irq_vec), 32'(m_vec));
    check("gnt", 32'(br_gnt), 32'(m_gnt));
  endtask
  task automatic do_reset();
    pir_in = '0; psw = '0; br_req = '0; iack = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask
  initial begin
    br_vec = 36'({$urandom(), $urandom()});
    do_reset();
    check("rst_irq", 32'(cpu_irq), 0);
    check("rst_gnt", 32'(br_gnt), 0);
    pir_in = 16'(1) << 13; psw = 3'd3;
    tick();
    check("s1_irq", 32'(cpu_irq), 1);
    check("s1_lvl", 32'(cpu_irq_lvl), 5);
    check("s1_vec", 32'(cpu_irq_vec), 32'o240);
    iack = 1'b1;
    tick();
    iack = 1'b0; pir_in = '0;
    check("s1_drop", 32'(cpu_irq), 0);
    check("s1_nognt", 32'(br_gnt), 0);
    do_reset();
    br_vec[9 +: 9] = 9'o060;
    br_req = 4'b0010; pir_in = 16'(1) << 13;
    tick();
    check("s2_lvl", 32'(cpu_irq_lvl), 5);
    check("s2_vec", 32'(cpu_irq_vec), 32'o060);
    iack = 1'b1;
    tick();
    iack = 1'b0; br_req = '0;
    check("s2_gnt", 32'(br_gnt), 32'b0010);
    tick();
    check("s2_gnt_off", 32'(br_gnt), 0);
    do_reset();
    br_req = 4'b0001;
    tick();
    check("s3_lvl", 32'(cpu_irq_lvl), 4);
    psw = 3'd4;
    tick();
    check("s3_drop", 32'(cpu_irq), 0);
    tick();
    check("s3_nognt", 32'(br_gnt), 0);
    do_reset();
    br_vec[18 +: 9] = 9'o100; br_vec[27 +: 9] = 9'o200;
    br_req = 4'b0100;
    tick();
    check("s4_lvl6", 32'(cpu_irq_lvl), 6);
    br_req = 4'b1100;
    tick();
    check("s4_frozen", 32'(cpu_irq_lvl), 6);
    iack = 1'b1;
    tick();
    iack = 1'b0; br_req = 4'b1000;
    check("s4_gnt", 32'(br_gnt), 32'b0100);
    tick();
    check("s4_hold1", 32'(cpu_irq), 0);
    tick();
    check("s4_hold2", 32'(cpu_irq), 0);
    tick();
    check("s4_irq7", 32'(cpu_irq), 1);
    check("s4_lvl7", 32'(cpu_irq_lvl), 7);
    check("s4_vec7", 32'(cpu_irq_vec), 32'o200);
    do_reset();
    br_req = 4'b0001;
    tick();
    br_req = 4'b0000; iack = 1'b1;
    tick();
    iack = 1'b0;
    check("s5_gnt", 32'(br_gnt), 32'b0001);
    tick();
    check("s5_once", 32'(br_gnt), 0);
    do_reset();
    br_req = 4'b0001;
    tick();
    check("s6_req", 32'(cpu_irq), 1);
    rst_n = 1'b0;
    tick();
    check("s6_irq", 32'(cpu_irq), 0);
    check("s6_lvl", 32'(cpu_irq_lvl), 0);
    check("s6_vec", 32'(cpu_irq_vec), 0);
    rst_n = 1'b1; br_req = '0; iack = 1'b1;
    tick();
    iack = 1'b0;
    check("s6_stray", 32'(br_gnt), 0);
    for (int n = 0; n < 3000; n++) begin
      rst_n = $urandom_range(199) != 0;
      iack = $urandom_range(3) == 0;
      if ($urandom_range(3) == 0) psw = 3'($urandom_range(7));
      if ($urandom_range(4) == 0) br_req = 4'($urandom & $urandom);
      if ($urandom_range(4) == 0) pir_in = 16'($urandom & $urandom & $urandom);
      if ($urandom_range(15) == 0) br_vec = 36'({$urandom(), $urandom()});
      tick();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
